// File: rtl/fetch_stage_pkg.sv
// Shared CPU constants for the fetch stage: default widths, NOP encoding, fetch FSM states.
package fetch_stage_pkg;

    localparam int          ADDR_W_DEF = 32;
    localparam int          DATA_W_DEF = 32;
    localparam logic [31:0] NOP_INSN   = 32'h0000_0000;

    localparam logic [0:0]  ST_RUN     = 1'b0;
    localparam logic [0:0]  ST_HOLD    = 1'b1;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load captures a new instruction, clear kills it, otherwise hold.
// Latency 1 cycle; no backpressure of its own, the caller decides load/clear/hold.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter int                ADDR_W = ADDR_W_DEF,
    parameter int                DATA_W = DATA_W_DEF,
    parameter logic [DATA_W-1:0] NOP    = DATA_W'(NOP_INSN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] next_ir,
    input  logic [ADDR_W-1:0] next_pc_one,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] pc_one,
    output logic              valid
);

    // pc_one is left untouched on clear so it stays deterministic while invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir     <= NOP;
            pc_one <= '0;
            valid  <= 1'b0;
        end else if (clear) begin
            ir     <= NOP;
            valid  <= 1'b0;
        end else if (load) begin
            ir     <= next_ir;
            pc_one <= next_pc_one;
            valid  <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register with a one-entry skid so stalls never drop an in-flight word.
// Latency: PC at t appears in IF/ID after edge t+1; stall holds IF/ID and parks the in-flight word.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                ADDR_W = ADDR_W_DEF,
    parameter int                DATA_W = DATA_W_DEF,
    parameter logic [DATA_W-1:0] NOP    = DATA_W'(NOP_INSN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc,
    input  logic              stall,
    input  logic              flush,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0] pc_inc,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] pc_one,
    output logic              valid
);

    logic [ADDR_W-1:0] f_pc;
    logic              f_live;
    logic [DATA_W-1:0] sk_ir;
    logic [ADDR_W-1:0] sk_pc;
    logic [0:0]        state;
    logic [0:0]        state_next;

    logic              load;
    logic              clear;
    logic              sk_capture;
    logic [DATA_W-1:0] next_ir;
    logic [ADDR_W-1:0] next_pc_one;

    assign imem_addr = pc;
    // A stalled PC is re-presented so the branch unit refetches the same address.
    assign pc_inc    = (stall && !flush) ? pc : pc + ADDR_W'(1);

    always_comb begin
        load        = 1'b0;
        clear       = 1'b0;
        sk_capture  = 1'b0;
        next_ir     = imem_rdata;
        next_pc_one = f_pc + ADDR_W'(1);
        state_next  = state;
        if (flush) begin
            clear      = 1'b1;
            state_next = ST_RUN;
        end else if (state == ST_RUN) begin
            if (stall) begin
                if (f_live) begin
                    sk_capture = 1'b1;
                    state_next = ST_HOLD;
                end
            end else if (f_live) begin
                load = 1'b1;
            end else begin
                clear = 1'b1;
            end
        end else if (!stall) begin
            // Drain the skid; the word arriving now is a stale duplicate and is ignored.
            load        = 1'b1;
            next_ir     = sk_ir;
            next_pc_one = sk_pc;
            state_next  = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_pc   <= '0;
            f_live <= 1'b0;
            sk_ir  <= '0;
            sk_pc  <= '0;
            state  <= ST_RUN;
        end else begin
            f_pc   <= pc;
            f_live <= !stall && !flush;
            state  <= state_next;
            if (sk_capture) begin
                sk_ir <= imem_rdata;
                sk_pc <= f_pc + ADDR_W'(1);
            end
        end
    end

    if_id_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .NOP    (NOP)
    ) u_if_id (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .clear       (clear),
        .next_ir     (next_ir),
        .next_pc_one (next_pc_one),
        .ir          (ir),
        .pc_one      (pc_one),
        .valid       (valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed-vector bench for fetch_stage; memory returns address ^ A5A5_0000 one cycle late.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic        stall;
    logic        flush;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] pc_inc;
    logic [31:0] ir;
    logic [31:0] pc_one;
    logic        valid;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata <= imem_addr ^ K;

    fetch_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc         (pc),
        .stall      (stall),
        .flush      (flush),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .pc_inc     (pc_inc),
        .ir         (ir),
        .pc_one     (pc_one),
        .valid      (valid)
    );

    typedef struct {
        logic [31:0] pc;
        logic        stall;
        logic        flush;
        logic [31:0] inc;
        logic        v;
        logic [31:0] ir;
        logic [31:0] p1;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] w(input logic [31:0] a);
        return a ^ K;
    endfunction

    task automatic add(input logic [31:0] p, input logic s, input logic f,
                       input logic [31:0] inc, input logic v,
                       input logic [31:0] eir, input logic [31:0] p1);
        vec_t e;
        e.pc = p; e.stall = s; e.flush = f;
        e.inc = inc; e.v = v; e.ir = eir; e.p1 = p1;
        vecs.push_back(e);
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] got %h expected %h", name, idx, got, exp);
        end
    endtask

    initial begin
        // Each row: inputs for the cycle, and outputs visible during that cycle.
        add(32'd0,  0, 0, 32'd1,  0, 32'h0,    32'd0);
        add(32'd1,  0, 0, 32'd2,  0, 32'h0,    32'd0);
        add(32'd2,  0, 0, 32'd3,  1, w(0),     32'd1);
        add(32'd3,  0, 0, 32'd4,  1, w(1),     32'd2);
        add(32'd4,  0, 0, 32'd5,  1, w(2),     32'd3);
        add(32'd5,  1, 0, 32'd5,  1, w(3),     32'd4);
        add(32'd5,  0, 0, 32'd6,  1, w(3),     32'd4);
        add(32'd6,  0, 0, 32'd7,  1, w(4),     32'd5);
        add(32'd7,  0, 0, 32'd8,  1, w(5),     32'd6);
        add(32'd8,  0, 0, 32'd9,  1, w(6),     32'd7);
        add(32'd9,  1, 0, 32'd9,  1, w(7),     32'd8);
        add(32'd9,  1, 0, 32'd9,  1, w(7),     32'd8);
        add(32'd9,  1, 0, 32'd9,  1, w(7),     32'd8);
        add(32'd9,  1, 0, 32'd9,  1, w(7),     32'd8);
        add(32'd9,  0, 0, 32'd10, 1, w(7),     32'd8);
        add(32'd10, 0, 0, 32'd11, 1, w(8),     32'd9);
        add(32'd11, 0, 0, 32'd12, 1, w(9),     32'd10);
        add(32'd12, 1, 0, 32'd12, 1, w(10),    32'd11);
        add(32'd12, 1, 1, 32'd13, 1, w(10),    32'd11);
        add(32'h40, 0, 0, 32'h41, 0, 32'h0,    32'd11);
        add(32'h41, 0, 0, 32'h42, 0, 32'h0,    32'd11);
        add(32'h42, 0, 0, 32'h43, 1, w(32'h40), 32'h41);
        add(32'hFFFF_FFFF, 0, 0, 32'h0, 1, w(32'h41), 32'h42);
        add(32'd0,  0, 0, 32'd1,  1, w(32'h42), 32'h43);
        add(32'd1,  0, 0, 32'd2,  1, w(32'hFFFF_FFFF), 32'h0);
        add(32'd2,  0, 0, 32'd3,  1, w(0),     32'd1);

        rst_n = 1'b0;
        pc    = 32'h0;
        stall = 1'b0;
        flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_valid",  0, {31'h0, valid}, 32'h0);
        chk("rst_ir",     0, ir,     32'h0);
        chk("rst_pc_one", 0, pc_one, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            pc    = vecs[i].pc;
            stall = vecs[i].stall;
            flush = vecs[i].flush;
            #2;
            chk("pc_inc", i, pc_inc, vecs[i].inc);
            chk("valid",  i, {31'h0, valid}, {31'h0, vecs[i].v});
            chk("ir",     i, ir,     vecs[i].ir);
            chk("pc_one", i, pc_one, vecs[i].p1);
            @(posedge clk);
            #1;
        end

        // Enter HOLD, then reset asynchronously between edges.
        pc    = 32'd3;
        stall = 1'b1;
        @(posedge clk);
        #2;
        chk("hold_valid", 0, {31'h0, valid}, 32'h1);
        chk("hold_ir",    0, ir, w(1));
        rst_n = 1'b0;
        #1;
        chk("arst_valid",  0, {31'h0, valid}, 32'h0);
        chk("arst_ir",     0, ir,     32'h0);
        chk("arst_pc_one", 0, pc_one, 32'h0);
        stall = 1'b0;
        pc    = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_valid", 0, {31'h0, valid}, 32'h0);
        pc = 32'd1;
        @(posedge clk);
        #1;
        chk("post_rst_valid", 1, {31'h0, valid}, 32'h1);
        chk("post_rst_ir",    1, ir,     w(0));
        chk("post_rst_pc_one", 1, pc_one, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register. It sits between the PC/branch unit and decode.
- Drives the synchronous instruction memory from the registered `pc`. Aligns the returned word with its address and presents `ir`/`pc_one`/`valid` to decode.
- Generates `pc_inc`, the branch unit's sequential next-PC input (`pc_min_one`). When `stall` is high, `pc_inc` holds the PC so the branch unit refetches the same address.
- Includes a one-entry skid buffer so a stall never loses an in-flight instruction.

Parameters:
- `ADDR_W`, 32, PC / instruction-memory address width.
- `DATA_W`, 32, instruction width.
- `NOP`, 32'h0000_0000, instruction presented on `ir` when `valid`=0.

Ports:
- `clk`  input  1  system clock, all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `pc`  input  ADDR_W  current PC from the branch unit.
- `stall`  input  1  hazard unit: decode cannot accept a new instruction this cycle.
- `flush`  input  1  branch taken/jump resolved this cycle: discard all wrong-path instructions.
- `imem_addr`  output  ADDR_W  instruction-memory address; combinationally equal to `pc`.
- `imem_rdata`  input  DATA_W  memory data; word for the address presented in the previous cycle.
- `pc_inc`  output  ADDR_W  sequential next PC to the branch unit.
- `ir`  output  DATA_W  IF/ID instruction.
- `pc_one`  output  ADDR_W  IF/ID: address of `ir` plus 1.
- `valid`  output  1  IF/ID holds a live instruction.

Behaviour:
- One clock (`clk`); reset is asynchronous and active-low (`rst_n`). Reset is asynchronous in both assertion and effect.
- Reset values: `ir`=`NOP`, `pc_one`=0, `valid`=0, `f_live`=0, `f_pc`=0, skid empty, state=RUN.
- Reset asserted mid-operation clears everything immediately. The first fetch after release (pc=0) is live.

Fetch tracking:
- Every edge: `f_pc` <= `pc`, and `f_live` <= !`stall` & !`flush`.
- `imem_rdata` in cycle t belongs to `f_pc`; it is used only if `f_live`=1.

pc_inc (combinational):
- `pc_inc` = `stall` & !`flush` ? `pc` : `pc`+1, modulo 2^ADDR_W.
- Wrap: `pc`=32'hFFFF_FFFF gives `pc_inc`=0, and `pc_one` wraps identically.

States:
- RUN: skid empty.
- HOLD: skid holds (`sk_ir`, `sk_pc`).

Transitions and IF/ID updates, in priority order:
1. `flush`=1 (beats stall):
   - `valid`<=0, `ir`<=`NOP`; skid emptied; state RUN.
   - The in-flight word is dropped, and the fetch issued this cycle is non-live.
2. RUN, `stall`=1:
   - IF/ID holds.
   - If `f_live`: skid <= (`imem_rdata`, `f_pc`+1) and state goes to HOLD; otherwise remain RUN.
3. RUN, `stall`=0:
   - If `f_live`: `ir`<=`imem_rdata`, `pc_one`<=`f_pc`+1, `valid`<=1.
   - Otherwise: `valid`<=0, `ir`<=`NOP`.
4. HOLD, `stall`=1:
   - Everything holds. The in-flight fetch is non-live by construction, because the previous cycle stalled.
5. HOLD, `stall`=0:
   - IF/ID <= skid, `valid`<=1, state goes to RUN.
   - The in-flight word is non-live and is discarded. This cycle's fetch (same PC, reissued) is live.
- Result: no instruction is lost or duplicated across stalls of any length. A single-cycle stall costs exactly one decode cycle.
- `pc_one` is don't-care while `valid`=0 but must be deterministic: hold the previous value.
- Latency: PC presented at t → in IF/ID after edge t+1 (absent stall/flush).

Decomposition:
- Shared CPU package: `ADDR_W`/`DATA_W` defaults, the `NOP` encoding constant, and the RUN/HOLD state enum.
- Natural sub-module: `if_id_reg`, the IF/ID register with hold/clear controls.
- The skid register and FSM stay in `fetch_stage`.

Test Plan:
- Reset then free-run, memory word = address ^ 32'hA5A5_0000:
  - `valid` rises after the second edge.
  - IF/ID sequence is (ir=A5A5_0000, pc_one=1), (A5A5_0001, 2), ….
  - `pc_inc` = `pc`+1 every cycle.
- Single stall while `pc`=5 (in-flight word 4):
  - `pc_inc`=5 during the stall; IF/ID holds word 3; skid captures word 4.
  - After release, IF/ID shows 4 then 5 with no gap or duplicate.
- 4-cycle stall: IF/ID and skid constant for all 4 cycles; then exactly 4, 5, 6 in order.
- `flush` with `stall` also high, branch to 0x40:
  - Next edge `valid`=0 and `ir`=`NOP`; skid empty.
  - First live IF/ID is (word 0x40, pc_one=0x41), two edges after flush.
- `pc`=32'hFFFF_FFFF: `pc_inc`=0 and IF/ID `pc_one`=0.
- Assert `rst_n`=0 asynchronously while in HOLD: outputs reset immediately without a clock edge, and the state is RUN after release.
